// File: rtl/mem_stage.sv
// MEM pipeline stage: EXE->MEM register, valid/allowin handshake, load extraction, exception and forwarding outputs.
// Optional load/stall performance counters are built in when MS_PERF_CNT_EN is defined.
module mem_stage #(
    parameter int AW      = 32,
    parameter int ECODE_W = 6
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               es_to_ms_valid,
    output logic               ms_allowin,
    input  logic [AW-1:0]      es_pc,
    input  logic [AW-1:0]      es_alu_result,
    input  logic               es_ld_en,
    input  logic [2:0]         es_ld_type,
    input  logic               es_gr_we,
    input  logic [4:0]         es_dest,
    input  logic               es_ex,
    input  logic [ECODE_W-1:0] es_ecode,
    input  logic [AW-1:0]      data_sram_rdata,
    input  logic               ws_allowin,
    input  logic               ms_flush,
    output logic               ms_to_ws_valid,
    output logic [AW-1:0]      ms_pc,
    output logic [AW-1:0]      ms_final_result,
    output logic               ms_gr_we,
    output logic [4:0]         ms_dest,
    output logic               ms_ex,
    output logic [ECODE_W-1:0] ms_ecode,
    output logic               ms_fwd_we,
    output logic [4:0]         ms_fwd_dest,
    output logic [AW-1:0]      ms_fwd_data
`ifdef MS_PERF_CNT_EN
    ,
    output logic [31:0]        ms_perf_load_cnt,
    output logic [31:0]        ms_perf_stall_cnt
`endif
);

    logic               ms_valid;
    logic               ms_ready_go;
    logic               accept;
    logic               first_cycle;
    logic [AW-1:0]      rdata_held;
    logic [AW-1:0]      ms_alu_result;
    logic               ms_ld_en;
    logic [2:0]         ms_ld_type;
    logic               ms_gr_we_raw;
    logic [AW-1:0]      ld_word;
    logic [7:0]         ld_byte;
    logic [15:0]        ld_half;
    logic [AW-1:0]      ld_data;

    assign ms_ready_go    = 1'b1;
    assign ms_allowin     = !ms_valid | (ms_ready_go & ws_allowin);
    assign ms_to_ws_valid = ms_valid & ms_ready_go & !ms_flush;
    assign accept         = es_to_ms_valid & ms_allowin;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ms_valid <= 1'b0;
        end else if (ms_flush) begin
            ms_valid <= 1'b0;
        end else if (ms_allowin) begin
            ms_valid <= es_to_ms_valid;
        end
    end

    // Payload still latches under flush; ms_valid being cleared discards it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ms_pc         <= '0;
            ms_alu_result <= '0;
            ms_ld_en      <= 1'b0;
            ms_ld_type    <= 3'd0;
            ms_gr_we_raw  <= 1'b0;
            ms_dest       <= 5'd0;
            ms_ex         <= 1'b0;
            ms_ecode      <= '0;
        end else if (accept) begin
            ms_pc         <= es_pc;
            ms_alu_result <= es_alu_result;
            ms_ld_en      <= es_ld_en;
            ms_ld_type    <= es_ld_type;
            ms_gr_we_raw  <= es_gr_we;
            ms_dest       <= es_dest;
            ms_ex         <= es_ex;
            ms_ecode      <= es_ecode;
        end
    end

    // SRAM data is only valid in the first MEM cycle; keep a copy for WB stalls.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            first_cycle <= 1'b0;
            rdata_held  <= '0;
        end else begin
            first_cycle <= accept;
            if (first_cycle) begin
                rdata_held <= data_sram_rdata;
            end
        end
    end

    always_comb begin
        ld_word = first_cycle ? data_sram_rdata : rdata_held;
        case (ms_alu_result[1:0])
            2'd0:    ld_byte = ld_word[7:0];
            2'd1:    ld_byte = ld_word[15:8];
            2'd2:    ld_byte = ld_word[23:16];
            default: ld_byte = ld_word[31:24];
        endcase
        ld_half = ms_alu_result[1] ? ld_word[31:16] : ld_word[15:0];
        case (ms_ld_type)
            3'd0:    ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'd1:    ld_data = {{16{ld_half[15]}}, ld_half};
            3'd3:    ld_data = {24'd0, ld_byte};
            3'd4:    ld_data = {16'd0, ld_half};
            default: ld_data = ld_word;
        endcase
    end

    // An excepting load reports its address so WB can load BADV.
    assign ms_final_result = (ms_ld_en & !ms_ex) ? ld_data : ms_alu_result;
    assign ms_gr_we        = ms_gr_we_raw & !ms_ex;

    assign ms_fwd_we   = ms_valid & ms_gr_we & (ms_dest != 5'd0);
    assign ms_fwd_dest = ms_dest;
    assign ms_fwd_data = ms_final_result;

`ifdef MS_PERF_CNT_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ms_perf_load_cnt  <= 32'd0;
            ms_perf_stall_cnt <= 32'd0;
        end else begin
            if (ms_to_ws_valid & ws_allowin & ms_ld_en) begin
                ms_perf_load_cnt <= ms_perf_load_cnt + 32'd1;
            end
            if (ms_valid & !ws_allowin & !ms_flush) begin
                ms_perf_stall_cnt <= ms_perf_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: instruction-level reference model compared every cycle,
// plus directed literal checks on the load, stall, exception, flush and reset scenarios.
module tb_mem_stage;

    logic        clk;
    logic        resetn;
    logic        es_to_ms_valid;
    logic        ms_allowin;
    logic [31:0] es_pc;
    logic [31:0] es_alu_result;
    logic        es_ld_en;
    logic [2:0]  es_ld_type;
    logic        es_gr_we;
    logic [4:0]  es_dest;
    logic        es_ex;
    logic [5:0]  es_ecode;
    logic [31:0] data_sram_rdata;
    logic        ws_allowin;
    logic        ms_flush;
    logic        ms_to_ws_valid;
    logic [31:0] ms_pc;
    logic [31:0] ms_final_result;
    logic        ms_gr_we;
    logic [4:0]  ms_dest;
    logic        ms_ex;
    logic [5:0]  ms_ecode;
    logic        ms_fwd_we;
    logic [4:0]  ms_fwd_dest;
    logic [31:0] ms_fwd_data;

    int total = 0;
    int bad   = 0;

    mem_stage dut (
        .clk             (clk),
        .resetn          (resetn),
        .es_to_ms_valid  (es_to_ms_valid),
        .ms_allowin      (ms_allowin),
        .es_pc           (es_pc),
        .es_alu_result   (es_alu_result),
        .es_ld_en        (es_ld_en),
        .es_ld_type      (es_ld_type),
        .es_gr_we        (es_gr_we),
        .es_dest         (es_dest),
        .es_ex           (es_ex),
        .es_ecode        (es_ecode),
        .data_sram_rdata (data_sram_rdata),
        .ws_allowin      (ws_allowin),
        .ms_flush        (ms_flush),
        .ms_to_ws_valid  (ms_to_ws_valid),
        .ms_pc           (ms_pc),
        .ms_final_result (ms_final_result),
        .ms_gr_we        (ms_gr_we),
        .ms_dest         (ms_dest),
        .ms_ex           (ms_ex),
        .ms_ecode        (ms_ecode),
        .ms_fwd_we       (ms_fwd_we),
        .ms_fwd_dest     (ms_fwd_dest),
        .ms_fwd_data     (ms_fwd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the instruction currently held by MEM and the word its load sees.
    bit          m_valid;
    bit          m_fresh;
    logic [31:0] m_word;
    logic [31:0] m_pc, m_alu;
    bit          m_ld, m_we, m_ex;
    int          m_type;
    logic [4:0]  m_dest;
    logic [5:0]  m_ecode;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_valid = 0; m_fresh = 0; m_word = 0;
            m_pc = 0; m_alu = 0; m_ld = 0; m_we = 0; m_ex = 0;
            m_type = 0; m_dest = 0; m_ecode = 0;
        end else begin
            bit room;
            bit take;
            room = !m_valid || ws_allowin;
            take = es_to_ms_valid && room;
            if (m_fresh) m_word = data_sram_rdata;
            m_fresh = take;
            if (take) begin
                m_pc = es_pc; m_alu = es_alu_result; m_ld = es_ld_en;
                m_type = int'(es_ld_type); m_we = es_gr_we; m_dest = es_dest;
                m_ex = es_ex; m_ecode = es_ecode;
            end
            if (ms_flush) m_valid = 0;
            else if (room) m_valid = es_to_ms_valid;
        end
    end

    function automatic logic [31:0] model_result();
        logic [31:0] w;
        int          off;
        int          b;
        int          h;
        if (!m_ld || m_ex) return m_alu;
        w   = m_fresh ? data_sram_rdata : m_word;
        off = int'(m_alu[1:0]);
        b   = int'((w >> (8 * off)) & 32'hFF);
        h   = int'((w >> (16 * (off / 2))) & 32'hFFFF);
        case (m_type)
            0:       return (b >= 128) ? 32'(b - 256) : 32'(b);
            1:       return (h >= 32768) ? 32'(h - 65536) : 32'(h);
            3:       return 32'(b);
            4:       return 32'(h);
            default: return w;
        endcase
    endfunction

    always @(negedge clk) begin
        logic [31:0] exp_res;
        bit          exp_we;
        exp_res = model_result();
        exp_we  = m_we && !m_ex;
        chk("to_ws_valid", 32'(ms_to_ws_valid), 32'(m_valid && !ms_flush));
        chk("allowin",     32'(ms_allowin),     32'(!m_valid || ws_allowin));
        chk("pc",          ms_pc,               m_pc);
        chk("final",       ms_final_result,     exp_res);
        chk("gr_we",       32'(ms_gr_we),       32'(exp_we));
        chk("dest",        32'(ms_dest),        32'(m_dest));
        chk("ex",          32'(ms_ex),          32'(m_ex));
        chk("ecode",       32'(ms_ecode),       32'(m_ecode));
        chk("fwd_we",      32'(ms_fwd_we),      32'(m_valid && exp_we && m_dest != 0));
        chk("fwd_dest",    32'(ms_fwd_dest),    32'(m_dest));
        chk("fwd_data",    ms_fwd_data,         exp_res);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sense();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] pc, input logic [31:0] alu, input logic ld,
                        input logic [2:0] typ, input logic we, input logic [4:0] dest,
                        input logic ex, input logic [5:0] ecode);
        es_to_ms_valid = 1'b1;
        es_pc = pc; es_alu_result = alu; es_ld_en = ld; es_ld_type = typ;
        es_gr_we = we; es_dest = dest; es_ex = ex; es_ecode = ecode;
    endtask

    task automatic idle();
        es_to_ms_valid = 1'b0;
    endtask

    initial begin
        resetn = 1'b0; es_to_ms_valid = 1'b0; es_pc = 0; es_alu_result = 0;
        es_ld_en = 0; es_ld_type = 0; es_gr_we = 0; es_dest = 0; es_ex = 0; es_ecode = 0;
        data_sram_rdata = 0; ws_allowin = 1'b1; ms_flush = 1'b0;
        #3;
        chk("rst_to_ws_valid", 32'(ms_to_ws_valid), 32'h0);
        chk("rst_fwd_we", 32'(ms_fwd_we), 32'h0);
        chk("rst_pc", ms_pc, 32'h0);
        chk("rst_final", ms_final_result, 32'h0);
        tick(); tick();
        resetn = 1'b1;
        tick();

        // ld.b then ld.bu, same address, back-to-back
        send(32'h100, 32'h1003, 1, 3'd0, 1, 5'd3, 0, 6'd0);
        tick();
        send(32'h104, 32'h1003, 1, 3'd3, 1, 5'd3, 0, 6'd0);
        data_sram_rdata = 32'h80FF_1234;
        sense();
        chk("ld_b", ms_final_result, 32'hFFFF_FF80);
        chk("ld_b_we", 32'(ms_gr_we), 32'h1);
        tick();
        idle();
        sense();
        chk("ld_bu", ms_final_result, 32'h0000_0080);

        // ld.h / ld.hu at 0x1002, ld.h at 0x1000
        tick();
        send(32'h108, 32'h1002, 1, 3'd1, 1, 5'd4, 0, 6'd0);
        tick();
        send(32'h10C, 32'h1002, 1, 3'd4, 1, 5'd4, 0, 6'd0);
        data_sram_rdata = 32'h8001_7FFF;
        sense();
        chk("ld_h", ms_final_result, 32'hFFFF_8001);
        tick();
        send(32'h110, 32'h1000, 1, 3'd1, 1, 5'd4, 0, 6'd0);
        sense();
        chk("ld_hu", ms_final_result, 32'h0000_8001);
        tick();
        idle();
        sense();
        chk("ld_h_lo", ms_final_result, 32'h0000_7FFF);

        // back-to-back ld.w, each sees its own first-cycle word; type 6 behaves as ld.w
        tick();
        send(32'h114, 32'h2000, 1, 3'd2, 1, 5'd6, 0, 6'd0);
        tick();
        send(32'h118, 32'h2004, 1, 3'd6, 1, 5'd6, 0, 6'd0);
        data_sram_rdata = 32'h1111_1111;
        sense();
        chk("b2b_first", ms_final_result, 32'h1111_1111);
        tick();
        idle();
        data_sram_rdata = 32'h2222_2222;
        sense();
        chk("b2b_second", ms_final_result, 32'h2222_2222);

        // WB stall for 3 cycles, SRAM data changes after the first cycle
        tick();
        send(32'h11C, 32'h3000, 1, 3'd2, 1, 5'd7, 0, 6'd0);
        ws_allowin = 1'b0;
        tick();
        idle();
        data_sram_rdata = 32'hCAFE_F00D;
        sense();
        chk("stall_c1", ms_final_result, 32'hCAFE_F00D);
        chk("stall_c1_allowin", 32'(ms_allowin), 32'h0);
        tick();
        data_sram_rdata = 32'hDEAD_BEEF;
        sense();
        chk("stall_c2", ms_final_result, 32'hCAFE_F00D);
        chk("stall_c2_allowin", 32'(ms_allowin), 32'h0);
        tick();
        sense();
        chk("stall_c3", ms_final_result, 32'hCAFE_F00D);
        tick();
        ws_allowin = 1'b1;
        sense();
        chk("stall_handoff", 32'(ms_to_ws_valid), 32'h1);
        chk("stall_c4", ms_final_result, 32'hCAFE_F00D);

        // non-load forwarding, then dest 0
        tick();
        send(32'h120, 32'h1234_5678, 0, 3'd0, 1, 5'd5, 0, 6'd0);
        tick();
        send(32'h124, 32'h1234_5678, 0, 3'd0, 1, 5'd0, 0, 6'd0);
        sense();
        chk("fwd_we_d5", 32'(ms_fwd_we), 32'h1);
        chk("fwd_dest_d5", 32'(ms_fwd_dest), 32'h5);
        chk("fwd_data_d5", ms_fwd_data, 32'h1234_5678);
        tick();
        idle();
        sense();
        chk("fwd_we_d0", 32'(ms_fwd_we), 32'h0);

        // excepting misaligned load
        tick();
        send(32'h128, 32'h1001, 1, 3'd2, 1, 5'd8, 1, 6'h09);
        tick();
        idle();
        data_sram_rdata = 32'hAAAA_5555;
        sense();
        chk("ale_ex", 32'(ms_ex), 32'h1);
        chk("ale_ecode", 32'(ms_ecode), 32'h09);
        chk("ale_we", 32'(ms_gr_we), 32'h0);
        chk("ale_final", ms_final_result, 32'h1001);

        // flush while MEM is valid and EXE offers a new instruction
        tick();
        send(32'h12C, 32'h55, 0, 3'd0, 1, 5'd9, 0, 6'd0);
        ws_allowin = 1'b0;
        tick();
        send(32'h130, 32'h66, 0, 3'd0, 1, 5'd10, 0, 6'd0);
        ms_flush = 1'b1;
        sense();
        chk("flush_to_ws", 32'(ms_to_ws_valid), 32'h0);
        tick();
        idle();
        ms_flush = 1'b0;
        ws_allowin = 1'b1;
        sense();
        chk("flush_after_valid", 32'(ms_to_ws_valid), 32'h0);
        chk("flush_after_fwd", 32'(ms_fwd_we), 32'h0);

        // async reset in the middle of a stalled load
        tick();
        send(32'h134, 32'h4000, 1, 3'd2, 1, 5'd11, 0, 6'd0);
        ws_allowin = 1'b0;
        tick();
        idle();
        data_sram_rdata = 32'h7777_8888;
        tick();
        resetn = 1'b0;
        #1;
        chk("rst_mid_to_ws", 32'(ms_to_ws_valid), 32'h0);
        chk("rst_mid_fwd_we", 32'(ms_fwd_we), 32'h0);
        chk("rst_mid_pc", ms_pc, 32'h0);
        chk("rst_mid_final", ms_final_result, 32'h0);
        chk("rst_mid_dest", 32'(ms_dest), 32'h0);
        tick();
        resetn = 1'b1;
        ws_allowin = 1'b1;
        tick(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
